// File: rtl/result_collector.sv
// ----------------------------------------------------------------------------
// result_collector
//
// Gathers one N x N result matrix whose elements arrive column by column with
// arbitrary skew between columns, and hands it to a consumer one complete,
// deskewed row at a time over a valid/ready handshake.
//
// Parameters
//   MATRIX_SIZE : N, number of columns and of result rows per matrix
//   DATA_SIZE   : width of one result element
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   reset      : asynchronous, active-high reset
//   enable     : global stall, when low nothing inside changes
//   start      : begin collecting a new matrix (honoured only in IDLE)
//   col_valid  : per-column qualifier for col_data
//   col_data   : column c at [c*DATA_SIZE +: DATA_SIZE]
//   out_valid  : a complete row is presented
//   out_ready  : consumer accepts the presented row
//   out_data   : presented row, column c at [c*DATA_SIZE +: DATA_SIZE]
//   out_row    : index of the presented row
//   busy       : FSM is collecting
//   done       : FSM is in DONE (one cycle after the last row is accepted)
//   overflow   : sticky, a column delivered more than N elements
// ----------------------------------------------------------------------------
module result_collector #(
    parameter int MATRIX_SIZE = 2,
    parameter int DATA_SIZE   = 32
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              enable,
    input  logic                              start,
    input  logic [MATRIX_SIZE-1:0]            col_valid,
    input  logic [MATRIX_SIZE*DATA_SIZE-1:0]  col_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [MATRIX_SIZE*DATA_SIZE-1:0]  out_data,
    output logic [$clog2(MATRIX_SIZE):0]      out_row,
    output logic                              busy,
    output logic                              done,
    output logic                              overflow
);

    localparam int N  = MATRIX_SIZE;
    // Counters and the row pointer must be able to hold the value N itself.
    localparam int CW = $clog2(N) + 1;
    // Index width for addressing one of N buffer rows.
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] N_CNT    = CW'(N);
    localparam logic [CW-1:0] LAST_ROW = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DONE
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [CW-1:0]          cnt [N];
    logic [CW-1:0]          rd_row;
    logic [DATA_SIZE-1:0]   row_buf [N][N];
    logic                   overflow_q;
    logic                   row_complete;
    logic                   transfer;
    logic [IW-1:0]          rd_idx;

    assign rd_idx = rd_row[IW-1:0];

    // The row under the read pointer is complete once every column has
    // delivered more elements than the row index.
    always_comb begin
        row_complete = 1'b1;
        for (int c = 0; c < N; c++) begin
            if (cnt[c] <= rd_row) begin
                row_complete = 1'b0;
            end
        end
    end

    assign out_valid = (state == COLLECT) && row_complete;
    assign transfer  = out_valid && out_ready && enable;
    assign busy      = (state == COLLECT);
    assign done      = (state == DONE);
    assign overflow  = overflow_q;

    // Present the buffered row only while valid; outputs are zero otherwise.
    always_comb begin
        out_data = '0;
        out_row  = '0;
        if (out_valid) begin
            out_row = rd_row;
            for (int c = 0; c < N; c++) begin
                out_data[c*DATA_SIZE +: DATA_SIZE] = row_buf[rd_idx][c];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (enable && start) begin
                    state_next = COLLECT;
                end
            end
            COLLECT: begin
                if (transfer && (rd_row == LAST_ROW)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (enable) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: per-column fill counters, row buffer, read pointer and the
    // sticky overflow flag. Capture and transfer are independent, so a row
    // can be drained in the same cycle another element lands.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_row     <= '0;
            overflow_q <= 1'b0;
            for (int r = 0; r < N; r++) begin
                cnt[r] <= '0;
                for (int c = 0; c < N; c++) begin
                    row_buf[r][c] <= '0;
                end
            end
        end else if (enable) begin
            if (state == IDLE && start) begin
                rd_row     <= '0;
                overflow_q <= 1'b0;
                for (int r = 0; r < N; r++) begin
                    cnt[r] <= '0;
                    for (int c = 0; c < N; c++) begin
                        row_buf[r][c] <= '0;
                    end
                end
            end else if (state == COLLECT) begin
                for (int c = 0; c < N; c++) begin
                    if (col_valid[c]) begin
                        if (cnt[c] < N_CNT) begin
                            row_buf[cnt[c][IW-1:0]][c] <= col_data[c*DATA_SIZE +: DATA_SIZE];
                            cnt[c] <= cnt[c] + CW'(1);
                        end else begin
                            overflow_q <= 1'b1;
                        end
                    end
                end
                if (transfer) begin
                    rd_row <= rd_row + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_result_collector.sv
// ----------------------------------------------------------------------------
// tb_result_collector
//
// Self-checking bench for result_collector with N=2, DATA_SIZE=32. A
// behavioural model keeps one queue of received samples per column and a
// count of rows already handed out; the expected outputs are derived from
// those after every clock edge.
// ----------------------------------------------------------------------------
module tb_result_collector;

    localparam int N  = 2;
    localparam int DW = 32;
    localparam int CW = $clog2(N) + 1;
    localparam int VW = 4 + CW + N*DW;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic              start;
    logic [N-1:0]      col_valid;
    logic [N*DW-1:0]   col_data;
    logic              out_valid;
    logic              out_ready;
    logic [N*DW-1:0]   out_data;
    logic [CW-1:0]     out_row;
    logic              busy;
    logic              done;
    logic              overflow;

    always #5 clk = ~clk;

    result_collector #(.MATRIX_SIZE(N), .DATA_SIZE(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .start     (start),
        .col_valid (col_valid),
        .col_data  (col_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_row   (out_row),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow)
    );

    int checks = 0;
    int passed = 0;

    // Behavioural model: phase 0 idle, 1 collecting, 2 finished.
    int              m_phase;
    logic [DW-1:0]   m_col [N][$];
    int              m_sent;
    bit              m_ovf;

    logic [VW-1:0]   exp_vec;
    logic [VW-1:0]   obs_vec;

    typedef struct {
        bit            en;
        bit            st;
        logic [N-1:0]  cv;
        logic [N*DW-1:0] cd;
    } step_t;

    step_t seq[$];

    function automatic step_t mk(bit en, bit st, logic [N-1:0] cv, logic [DW-1:0] d1, logic [DW-1:0] d0);
        step_t s;
        s.en = en;
        s.st = st;
        s.cv = cv;
        s.cd = {d1, d0};
        return s;
    endfunction

    function automatic logic [VW-1:0] model_outputs();
        bit              v;
        logic [N*DW-1:0] d;
        logic [CW-1:0]   r;
        v = (m_phase == 1);
        d = '0;
        r = '0;
        for (int c = 0; c < N; c++) begin
            if (m_col[c].size() <= m_sent) v = 1'b0;
        end
        if (v) begin
            r = CW'(m_sent);
            for (int c = 0; c < N; c++) d[c*DW +: DW] = m_col[c][m_sent];
        end
        return {v, r, (m_phase == 1), (m_phase == 2), m_ovf, d};
    endfunction

    function automatic logic [VW-1:0] observed();
        return {out_valid, out_row, busy, done, overflow, out_data};
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_sent  = 0;
        m_ovf   = 1'b0;
        for (int c = 0; c < N; c++) m_col[c].delete();
    endtask

    // Drive one cycle of inputs, advance the model across the clock edge,
    // then sample the DUT one time unit after the edge.
    task automatic applyStimulus(input bit en, input bit st, input logic [N-1:0] cv,
                                 input logic [N*DW-1:0] cd, input bit rdy);
        logic [VW-1:0] pre;
        bit            fire;
        enable    = en;
        start     = st;
        col_valid = cv;
        col_data  = cd;
        out_ready = rdy;
        pre  = model_outputs();
        fire = pre[VW-1] && rdy;
        @(posedge clk);
        if (en) begin
            case (m_phase)
                0: begin
                    if (st) begin
                        m_phase = 1;
                        m_sent  = 0;
                        m_ovf   = 1'b0;
                        for (int c = 0; c < N; c++) m_col[c].delete();
                    end
                end
                1: begin
                    for (int c = 0; c < N; c++) begin
                        if (cv[c]) begin
                            if (m_col[c].size() < N) m_col[c].push_back(cd[c*DW +: DW]);
                            else m_ovf = 1'b1;
                        end
                    end
                    if (fire) begin
                        m_sent++;
                        if (m_sent == N) m_phase = 2;
                    end
                end
                default: m_phase = 0;
            endcase
        end
        #1;
        exp_vec = model_outputs();
        obs_vec = observed();
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; start = 1'b0;
        col_valid = '0; col_data = '0; out_ready = 1'b0;
        model_reset();
        #1;
        obs_vec = observed();
        checks++; if (obs_vec !== '0) $display("[TB] FAIL reset_outputs obs=%h exp=0", obs_vec); else passed++;
        @(posedge clk); #1;
        reset = 1'b0;
        applyStimulus(1, 0, '0, '0, 0);
        checks++; if (obs_vec !== exp_vec) $display("[TB] FAIL reset_idle obs=%h exp=%h", obs_vec, exp_vec); else passed++;
    endtask

    task automatic test_skewed_fill();
        seq.delete();
        seq.push_back(mk(1, 1, 2'b00, 0, 0));
        seq.push_back(mk(1, 0, 2'b01, 0, 10));
        seq.push_back(mk(1, 0, 2'b11, 11, 20));
        seq.push_back(mk(1, 0, 2'b10, 21, 0));
        for (int i = 0; i < 4; i++) seq.push_back(mk(1, 0, 2'b00, 0, 0));
        foreach (seq[i]) begin
            applyStimulus(seq[i].en, seq[i].st, seq[i].cv, seq[i].cd, 1);
            checks++; if (obs_vec !== exp_vec) $display("[TB] FAIL skew step%0d obs=%h exp=%h", i, obs_vec, exp_vec); else passed++;
            if (i == 2) begin
                checks++;
                if (!(out_valid === 1'b1 && out_data === {32'd11, 32'd10} && out_row === 0))
                    $display("[TB] FAIL skew_row0 valid=%b data=%h row=%0d exp valid=1 data={11,10} row=0", out_valid, out_data, out_row);
                else passed++;
            end
            if (i == 3) begin
                checks++;
                if (!(out_valid === 1'b1 && out_data === {32'd21, 32'd20} && out_row === 1))
                    $display("[TB] FAIL skew_row1 valid=%b data=%h row=%0d exp valid=1 data={21,20} row=1", out_valid, out_data, out_row);
                else passed++;
            end
            if (i == 4) begin
                checks++;
                if (!(done === 1'b1 && busy === 1'b0))
                    $display("[TB] FAIL skew_done done=%b busy=%b exp done=1 busy=0", done, busy);
                else passed++;
            end
        end
    endtask

    task automatic test_backpressure();
        seq.delete();
        seq.push_back(mk(1, 1, 2'b00, 0, 0));
        seq.push_back(mk(1, 0, 2'b01, 0, 10));
        seq.push_back(mk(1, 0, 2'b11, 11, 20));
        seq.push_back(mk(1, 0, 2'b10, 21, 0));
        for (int i = 0; i < 7; i++) seq.push_back(mk(1, 0, 2'b00, 0, 0));
        foreach (seq[i]) begin
            applyStimulus(seq[i].en, seq[i].st, seq[i].cv, seq[i].cd, i >= 6);
            checks++; if (obs_vec !== exp_vec) $display("[TB] FAIL backpressure step%0d obs=%h exp=%h", i, obs_vec, exp_vec); else passed++;
            if (i >= 2 && i <= 5) begin
                checks++;
                if (!(out_valid === 1'b1 && out_data === {32'd11, 32'd10}))
                    $display("[TB] FAIL backpressure_hold step%0d valid=%b data=%h exp valid=1 data={11,10}", i, out_valid, out_data);
                else passed++;
            end
        end
    endtask

    task automatic test_overflow();
        seq.delete();
        seq.push_back(mk(1, 1, 2'b00, 0, 0));
        seq.push_back(mk(1, 0, 2'b01, 0, 1));
        seq.push_back(mk(1, 0, 2'b01, 0, 2));
        seq.push_back(mk(1, 0, 2'b01, 0, 3));
        seq.push_back(mk(1, 0, 2'b10, 5, 0));
        seq.push_back(mk(1, 0, 2'b10, 6, 0));
        for (int i = 0; i < 3; i++) seq.push_back(mk(1, 0, 2'b00, 0, 0));
        seq.push_back(mk(1, 1, 2'b00, 0, 0));
        seq.push_back(mk(1, 0, 2'b11, 8, 7));
        seq.push_back(mk(1, 0, 2'b11, 10, 9));
        for (int i = 0; i < 3; i++) seq.push_back(mk(1, 0, 2'b00, 0, 0));
        foreach (seq[i]) begin
            applyStimulus(seq[i].en, seq[i].st, seq[i].cv, seq[i].cd, 1);
            checks++; if (obs_vec !== exp_vec) $display("[TB] FAIL overflow step%0d obs=%h exp=%h", i, obs_vec, exp_vec); else passed++;
            if (i == 4) begin
                checks++;
                if (!(overflow === 1'b1 && out_data === {32'd5, 32'd1}))
                    $display("[TB] FAIL overflow_set ovf=%b data=%h exp ovf=1 data={5,1}", overflow, out_data);
                else passed++;
            end
            if (i == 8) begin
                checks++;
                if (overflow !== 1'b1) $display("[TB] FAIL overflow_sticky ovf=%b exp=1", overflow); else passed++;
            end
            if (i == 9) begin
                checks++;
                if (overflow !== 1'b0) $display("[TB] FAIL overflow_clear ovf=%b exp=0", overflow); else passed++;
            end
        end
    endtask

    task automatic test_stall();
        seq.delete();
        seq.push_back(mk(1, 1, 2'b00, 0, 0));
        seq.push_back(mk(1, 0, 2'b01, 0, 10));
        for (int i = 0; i < 3; i++) seq.push_back(mk(0, 1, 2'b11, $urandom, $urandom));
        seq.push_back(mk(1, 0, 2'b11, 11, 20));
        seq.push_back(mk(1, 0, 2'b10, 21, 0));
        for (int i = 0; i < 4; i++) seq.push_back(mk(1, 0, 2'b00, 0, 0));
        foreach (seq[i]) begin
            applyStimulus(seq[i].en, seq[i].st, seq[i].cv, seq[i].cd, 1);
            checks++; if (obs_vec !== exp_vec) $display("[TB] FAIL stall step%0d obs=%h exp=%h", i, obs_vec, exp_vec); else passed++;
            if (i == 5) begin
                checks++;
                if (!(out_valid === 1'b1 && out_data === {32'd11, 32'd10}))
                    $display("[TB] FAIL stall_row0 valid=%b data=%h exp valid=1 data={11,10}", out_valid, out_data);
                else passed++;
            end
        end
    endtask

    task automatic test_reset_mid();
        seq.delete();
        seq.push_back(mk(1, 1, 2'b00, 0, 0));
        seq.push_back(mk(1, 0, 2'b01, 0, 10));
        seq.push_back(mk(1, 0, 2'b11, 11, 20));
        foreach (seq[i]) begin
            applyStimulus(seq[i].en, seq[i].st, seq[i].cv, seq[i].cd, 0);
            checks++; if (obs_vec !== exp_vec) $display("[TB] FAIL reset_mid_fill step%0d obs=%h exp=%h", i, obs_vec, exp_vec); else passed++;
        end
        reset = 1'b1;
        #1;
        obs_vec = observed();
        checks++; if (obs_vec !== '0) $display("[TB] FAIL reset_mid_async obs=%h exp=0", obs_vec); else passed++;
        model_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        seq.delete();
        seq.push_back(mk(1, 1, 2'b00, 0, 0));
        seq.push_back(mk(1, 0, 2'b10, 40, 0));
        seq.push_back(mk(1, 0, 2'b11, 41, 30));
        seq.push_back(mk(1, 0, 2'b01, 0, 31));
        for (int i = 0; i < 4; i++) seq.push_back(mk(1, 0, 2'b00, 0, 0));
        foreach (seq[i]) begin
            applyStimulus(seq[i].en, seq[i].st, seq[i].cv, seq[i].cd, 1);
            checks++; if (obs_vec !== exp_vec) $display("[TB] FAIL reset_mid_fresh step%0d obs=%h exp=%h", i, obs_vec, exp_vec); else passed++;
        end
    endtask

    task automatic test_ignored_start();
        seq.delete();
        seq.push_back(mk(1, 1, 2'b00, 0, 0));
        seq.push_back(mk(1, 1, 2'b01, 0, 10));
        seq.push_back(mk(1, 1, 2'b11, 11, 20));
        seq.push_back(mk(1, 1, 2'b10, 21, 0));
        seq.push_back(mk(1, 1, 2'b00, 0, 0));
        for (int i = 0; i < 3; i++) seq.push_back(mk(1, 0, 2'b00, 0, 0));
        foreach (seq[i]) begin
            applyStimulus(seq[i].en, seq[i].st, seq[i].cv, seq[i].cd, 1);
            checks++; if (obs_vec !== exp_vec) $display("[TB] FAIL ignored_start step%0d obs=%h exp=%h", i, obs_vec, exp_vec); else passed++;
            if (i == 2) begin
                checks++;
                if (!(out_valid === 1'b1 && out_data === {32'd11, 32'd10}))
                    $display("[TB] FAIL ignored_start_row0 valid=%b data=%h exp valid=1 data={11,10}", out_valid, out_data);
                else passed++;
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(199, 0) == 0) begin
                reset = 1'b1;
                #1;
                obs_vec = observed();
                checks++; if (obs_vec !== '0) $display("[TB] FAIL random_reset cycle%0d obs=%h exp=0", i, obs_vec); else passed++;
                model_reset();
                @(posedge clk); #1;
                reset = 1'b0;
            end
            applyStimulus($urandom_range(99, 0) < 85,
                          $urandom_range(99, 0) < 15,
                          N'($urandom),
                          {$urandom, $urandom},
                          $urandom_range(99, 0) < 65);
            checks++; if (obs_vec !== exp_vec) $display("[TB] FAIL random cycle%0d obs=%h exp=%h", i, obs_vec, exp_vec); else passed++;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_skewed_fill();
        test_backpressure();
        test_overflow();
        test_stall();
        test_reset_mid();
        test_ignored_start();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/result_collector.md
RESULT_COLLECTOR -- requirements
Module: result_collector

Interface
REQ-001 The block SHALL have parameter MATRIX_SIZE, default 2: array dimension N, giving N columns and N result rows per matrix.
REQ-002 The block SHALL have parameter DATA_SIZE, default 32: width in bits of each result element.
REQ-003 The block SHALL have port clk, input, 1 bit: clock; all state changes on the rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-005 The block SHALL have port enable, input, 1 bit: global stall; when low, no internal state changes.
REQ-006 The block SHALL have port start, input, 1 bit: begins collection of one N x N result matrix.
REQ-007 The block SHALL have port col_valid, input, N bits: bit c qualifies the element on column c this cycle.
REQ-008 The block SHALL have port col_data, input, N*DATA_SIZE bits: column c occupies bits [c*DATA_SIZE +: DATA_SIZE].
REQ-009 The block SHALL have port out_valid, output, 1 bit: a complete, deskewed result row is presented.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the presented row.
REQ-011 The block SHALL have port out_data, output, N*DATA_SIZE bits: row elements, with column c at [c*DATA_SIZE +: DATA_SIZE].
REQ-012 The block SHALL have port out_row, output, $clog2(N)+1 bits: index of the presented row.
REQ-013 The block SHALL have port busy, output, 1 bit: high while the block is in state COLLECT.
REQ-014 The block SHALL have port done, output, 1 bit: one-cycle pulse after the last row is accepted.
REQ-015 The block SHALL have port overflow, output, 1 bit: sticky error flag.

Function
REQ-016 The FSM SHALL have states IDLE, COLLECT and DONE.
- IDLE -> COLLECT on start=1 and enable=1.
- COLLECT -> DONE on the transfer of row N-1.
- DONE -> IDLE unconditionally on the next enabled edge.
REQ-017 On entry to COLLECT:
- the per-column counters cnt[0..N-1] SHALL clear;
- the read row pointer rd_row SHALL clear;
- the row buffer (N rows x N columns) SHALL clear;
- overflow SHALL clear.
REQ-018 In COLLECT with enable=1, col_valid[c]=1 and cnt[c]<N, the block SHALL write col_data[c] to buf[cnt[c]][c] and increment cnt[c].
- Columns are independent.
- Any arrival skew between columns SHALL be tolerated.
REQ-019 In COLLECT, col_valid[c]=1 with cnt[c]==N SHALL drop the sample, set overflow=1, and leave cnt[c] unchanged.
REQ-020 col_valid SHALL be ignored in IDLE and DONE.
REQ-021 Row r is complete when cnt[c]>r for every c.
REQ-022 out_valid SHALL equal (state==COLLECT and row rd_row complete), decoded from registered state only.
- out_valid rises in the cycle after the edge that captures the last element of the row.
REQ-023 While out_valid=1, out_data SHALL equal buf[rd_row] and out_row SHALL equal rd_row; while out_valid=0, both SHALL be 0.
REQ-024 A transfer occurs when out_valid=1, out_ready=1 and enable=1; rd_row SHALL then increment.
REQ-025 Once asserted, out_valid and out_data SHALL hold stable until transfer or reset.
REQ-026 Rows SHALL be emitted strictly in order 0..N-1, one per cycle maximum.
- Back-to-back transfers are allowed when rows are already complete.
REQ-027 A capture and a transfer in the same cycle SHALL both take effect.
REQ-028 start SHALL be ignored in COLLECT and DONE.
REQ-029 With enable=0, the following SHALL be frozen, and col_valid, start and out_ready SHALL be ignored:
- FSM state;
- counters;
- buffer contents;
- rd_row;
- overflow.
REQ-030 done SHALL be 1 exactly while the FSM is in DONE.
REQ-031 busy SHALL be 1 exactly while the FSM is in COLLECT.
REQ-032 overflow SHALL remain set through DONE and IDLE until the next start or reset.

Reset
REQ-033 reset=1 SHALL asynchronously force all of the following, regardless of operation in progress:
- FSM state = IDLE;
- cnt = 0, rd_row = 0, buf = 0;
- out_valid = 0, out_data = 0, out_row = 0;
- busy = 0, done = 0, overflow = 0.
REQ-034 After reset deasserts, the block SHALL accept start on the first enabled edge.

Verification (N=2, DATA_SIZE=32)
REQ-035 Skewed fill:
- start; col0 = 10 at t1, 20 at t2; col1 = 11 at t2, 21 at t3; out_ready=1.
- Expect row0 {11,10} out_valid in cycle t3, row1 {21,20} in cycle t4, done one cycle after row1 transfer, busy low afterwards.
REQ-036 Backpressure:
- Same stimulus with out_ready=0 until t6.
- Expect out_valid=1 with row0 held stable t3..t6.
- row1 presented the cycle after row0 transfer; no data loss.
REQ-037 Overflow:
- Three valids on col0 in one collection.
- Expect the third sample dropped, overflow=1 sticky through DONE, cleared by the next start.
REQ-038 Stall:
- enable=0 for 3 cycles mid-fill with col_valid=1.
- Expect no counter or buffer change during the stall; results identical to REQ-035 shifted by 3 cycles.
REQ-039 Reset mid-operation:
- Assert reset after row0 captured, before transfer.
- Expect immediate out_valid=0, busy=0, all outputs 0.
- A fresh start then collects correctly.
REQ-040 Ignored start:
- Pulse start during COLLECT.
- Expect no counter clear and rows unaffected.
